// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared configuration for the rv32i instruction-fetch stage: reset vector,
// NOP encoding, fetch FSM state encoding and the IF/ID pipeline entry layout.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int                    INST_WIDTH      = 32;
  localparam int                    MEM_SIZE_DEFAULT = 1024;
  localparam logic [31:0]           RESET_VECTOR    = 32'h0000_0000;
  // addi x0, x0, 0 -- substituted for instructions fetched outside memory
  localparam logic [INST_WIDTH-1:0] NOP_INSTR       = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_FETCH = 2'b01,
    S_HALT  = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]           pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  misaligned;
    logic                  fault;
  } if_id_t;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// IF/ID hand-off bundle between the fetch stage (master) and decode (slave).
//   valid      : entry valid                       (fetch -> decode)
//   pc         : PC of the entry                   (fetch -> decode)
//   inst       : instruction, NOP on fault         (fetch -> decode)
//   misaligned : entry came from a misaligned redirect target
//   fault      : entry PC outside the instruction memory window
//   ready      : decode accepts the entry this cycle (decode -> fetch)
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic                  valid;
  logic [31:0]           pc;
  logic [INST_WIDTH-1:0] inst;
  logic                  misaligned;
  logic                  fault;
  logic                  ready;

  modport master (
    output valid, pc, inst, misaligned, fault,
    input  ready
  );

  modport slave (
    input  valid, pc, inst, misaligned, fault,
    output ready
  );

endinterface : fetch_stage_if

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// Single-entry valid/ready holding register for the IF/ID pipeline entry.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : drop the held entry (highest priority)
//   load_i        : capture data_i as a new valid entry
//   ready_i       : downstream consumes the held entry this cycle
//   data_i        : entry to capture
//   valid_o       : entry valid
//   data_o        : held entry
// The caller only asserts load_i when the slot is empty or being consumed.
// -----------------------------------------------------------------------------
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   flush_i,
  input  logic   load_i,
  input  logic   ready_i,
  input  if_id_t data_i,
  output logic   valid_o,
  output if_id_t data_o
);

  logic   valid_q, valid_d;
  if_id_t data_q,  data_d;

  // Next entry: flush > load > drain > hold
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// IF stage of the rv32i core. Owns the PC, addresses the combinational
// instruction memory and registers {pc, instruction} into the IF/ID entry.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   imem_addr_o     : byte address to instruction memory (low bits of PC)
//   imem_inst_i     : instruction returned in the same cycle
//   redirect_i      : branch/jump/resume taken; redirect_pc_i is the target
//   halt_i          : ecall/ebreak retired, stop fetching
//   if_id           : IF/ID entry bundle (master side)
//   halted_o        : fetch FSM is halted
// Per-cycle priority: redirect > halt > stall > advance.
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          MEM_SIZE = MEM_SIZE_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  output logic [$clog2(MEM_SIZE)-1:0] imem_addr_o,
  input  logic [INST_WIDTH-1:0]       imem_inst_i,
  input  logic                        redirect_i,
  input  logic [31:0]                 redirect_pc_i,
  input  logic                        halt_i,
  fetch_stage_if.master               if_id,
  output logic                        halted_o
);

  localparam int          AW        = $clog2(MEM_SIZE);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);

  localparam logic [1:0] ST_BOOT  = S_BOOT;
  localparam logic [1:0] ST_FETCH = S_FETCH;
  localparam logic [1:0] ST_HALT  = S_HALT;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic        halted_q, halted_d;

  logic        capture_s;
  logic        flush_s;
  logic        fault_s;
  logic        valid_s;
  if_id_t      entry_s;
  if_id_t      held_s;

  // PC, FSM and capture control
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    capture_s  = 1'b0;
    flush_s    = 1'b0;
    if (redirect_i) begin
      // Redirect overrides halt and stall in every state; the old entry is dropped
      flush_s    = 1'b1;
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      misalign_d = |redirect_pc_i[1:0];
      state_d    = ST_FETCH;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (halt_i) begin
            state_d = ST_HALT;
          end else if (!valid_s || if_id.ready) begin
            capture_s  = 1'b1;
            pc_d       = pc_q + 32'd4;
            // The misalign flag belongs to the first entry after the redirect only
            misalign_d = 1'b0;
          end else begin
            pc_d = pc_q;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          // Illegal encoding: restart fetch cleanly
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  assign fault_s = (pc_q >= MEM_LIMIT);

  // Build the entry to capture; out-of-window fetches become a flagged NOP
  always_comb begin
    entry_s            = '0;
    entry_s.pc         = pc_q;
    entry_s.misaligned = misalign_q;
    if (fault_s) begin
      entry_s.inst  = NOP_INSTR;
      entry_s.fault = 1'b1;
    end else begin
      entry_s.inst  = imem_inst_i;
      entry_s.fault = 1'b0;
    end
  end

  assign halted_d = (state_d == ST_HALT);

  // PC, FSM state and halted flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      halted_q   <= halted_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_s),
    .load_i  (capture_s),
    .ready_i (if_id.ready),
    .data_i  (entry_s),
    .valid_o (valid_s),
    .data_o  (held_s)
  );

  assign imem_addr_o      = pc_q[AW-1:0];
  assign if_id.valid      = valid_s;
  assign if_id.pc         = held_s.pc;
  assign if_id.inst       = held_s.inst;
  assign if_id.misaligned = held_s.misaligned;
  assign if_id.fault      = held_s.fault;
  assign halted_o         = halted_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. Two instances share the stimulus: dut_b with
// a 1024-byte window and dut_s with a 64-byte window (fault behaviour).
// The memory model returns the word index: mem[w] = w.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] rpc;
  logic        halt;
  logic [9:0]  addr_b;
  logic [5:0]  addr_s;
  logic [31:0] inst_b;
  logic [31:0] inst_s;
  logic        halted_b;
  logic        halted_s;

  int checks_cnt = 0;
  int errors_cnt = 0;

  fetch_stage_if ifb ();
  fetch_stage_if ifs ();

  assign inst_b = {24'd0, addr_b[9:2]};
  assign inst_s = {28'd0, addr_s[5:2]};

  fetch_stage #(.MEM_SIZE(1024), .RESET_PC(32'h0000_0000)) dut_b (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_addr_o   (addr_b),
    .imem_inst_i   (inst_b),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .halt_i        (halt),
    .if_id         (ifb),
    .halted_o      (halted_b)
  );

  fetch_stage #(.MEM_SIZE(64), .RESET_PC(32'h0000_0000)) dut_s (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_addr_o   (addr_s),
    .imem_inst_i   (inst_s),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .halt_i        (halt),
    .if_id         (ifs),
    .halted_o      (halted_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic mis);
    chk({tag, "_valid"}, 32'(ifb.valid), 32'd1);
    chk({tag, "_pc"},    ifb.pc, pc);
    chk({tag, "_inst"},  ifb.inst, inst);
    chk({tag, "_mis"},   32'(ifb.misaligned), 32'(mis));
    chk({tag, "_fault"}, 32'(ifb.fault), 32'd0);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    redirect  = 1'b0;
    rpc       = 32'd0;
    halt      = 1'b0;
    ifb.ready = 1'b1;
    ifs.ready = 1'b1;

    // Reset state
    nxt();
    chk("rst_valid",  32'(ifb.valid), 32'd0);
    chk("rst_pc",     ifb.pc, 32'd0);
    chk("rst_inst",   ifb.inst, 32'd0);
    chk("rst_halted", 32'(halted_b), 32'd0);
    chk("rst_addr",   32'(addr_b), 32'd0);
    nxt();
    rst_n = 1'b1;

    // Boot cycle, then sequential fetch 0,4,8,12
    nxt();
    chk("boot_valid", 32'(ifb.valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk_entry($sformatf("seq%0d", i), 32'(4 * i), 32'(i), 1'b0);
      if (i == 0) begin
        chk("small_seq0_fault", 32'(ifs.fault), 32'd0);
        chk("small_seq0_inst",  ifs.inst, 32'd0);
      end
    end

    // Aligned redirect to 8 with ready high, then a 3-cycle stall on pc=8
    redirect = 1'b1;
    rpc      = 32'h0000_0008;
    nxt();
    chk("rd8_gap_valid", 32'(ifb.valid), 32'd0);
    redirect = 1'b0;
    nxt();
    chk_entry("rd8", 32'h8, 32'd2, 1'b0);
    ifb.ready = 1'b0;
    ifs.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk_entry($sformatf("stall%0d", k), 32'h8, 32'd2, 1'b0);
      chk($sformatf("stall%0d_addr", k), 32'(addr_b), 32'h00C);
    end
    ifb.ready = 1'b1;
    ifs.ready = 1'b1;
    nxt();
    chk_entry("resume", 32'hC, 32'd3, 1'b0);

    // Redirect to 0x40 while stalled: held entry dropped
    ifb.ready = 1'b0;
    ifs.ready = 1'b0;
    nxt();
    chk_entry("hold12", 32'hC, 32'd3, 1'b0);
    redirect = 1'b1;
    rpc      = 32'h0000_0040;
    nxt();
    chk("rd40_gap_valid", 32'(ifb.valid), 32'd0);
    redirect  = 1'b0;
    ifb.ready = 1'b1;
    ifs.ready = 1'b1;
    nxt();
    chk_entry("rd40", 32'h40, 32'h10, 1'b0);
    chk("small_rd40_pc",    ifs.pc, 32'h40);
    chk("small_rd40_fault", 32'(ifs.fault), 32'd1);
    chk("small_rd40_inst",  ifs.inst, 32'h13);

    // Misaligned redirect 0x42: flag on the first entry only
    redirect = 1'b1;
    rpc      = 32'h0000_0042;
    nxt();
    chk("rd42_gap_valid", 32'(ifb.valid), 32'd0);
    redirect = 1'b0;
    nxt();
    chk_entry("rd42", 32'h40, 32'h10, 1'b1);
    nxt();
    chk_entry("rd42_next", 32'h44, 32'h11, 1'b0);

    // Halt and redirect together: redirect wins
    halt     = 1'b1;
    redirect = 1'b1;
    rpc      = 32'h0000_0080;
    nxt();
    chk("hr_halted", 32'(halted_b), 32'd0);
    chk("hr_valid",  32'(ifb.valid), 32'd0);
    halt     = 1'b0;
    redirect = 1'b0;
    nxt();
    chk_entry("rd80", 32'h80, 32'h20, 1'b0);
    chk("small_rd80_fault", 32'(ifs.fault), 32'd1);

    // Halt with a held entry: it drains, no new captures, pc frozen
    halt      = 1'b1;
    ifb.ready = 1'b0;
    ifs.ready = 1'b0;
    nxt();
    chk("halt_halted",   32'(halted_b), 32'd1);
    chk("halt_s_halted", 32'(halted_s), 32'd1);
    chk_entry("halt_held", 32'h80, 32'h20, 1'b0);
    chk("halt_s_held_fault", 32'(ifs.fault), 32'd1);
    chk("halt_s_held_inst",  ifs.inst, 32'h13);
    halt      = 1'b0;
    ifb.ready = 1'b1;
    ifs.ready = 1'b1;
    nxt();
    chk("drain_valid",   32'(ifb.valid), 32'd0);
    chk("drain_s_valid", 32'(ifs.valid), 32'd0);
    nxt();
    chk("halt_idle_valid",  32'(ifb.valid), 32'd0);
    chk("halt_idle_halted", 32'(halted_b), 32'd1);
    chk("halt_addr_b",      32'(addr_b), 32'h084);
    chk("halt_addr_s",      32'(addr_s), 32'h04);

    // Resume from halt via redirect to 0x18
    redirect = 1'b1;
    rpc      = 32'h0000_0018;
    nxt();
    chk("resume_halted", 32'(halted_b), 32'd0);
    chk("resume_valid",  32'(ifb.valid), 32'd0);
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk_entry($sformatf("run%0d", i), 32'(32'h18 + 4 * i), 32'(6 + i), 1'b0);
    end

    // Reset mid-stream at pc=0x20: outputs clear immediately
    rst_n = 1'b0;
    #1;
    chk("mrst_valid",  32'(ifb.valid), 32'd0);
    chk("mrst_pc",     ifb.pc, 32'd0);
    chk("mrst_inst",   ifb.inst, 32'd0);
    chk("mrst_halted", 32'(halted_b), 32'd0);
    chk("mrst_addr",   32'(addr_b), 32'd0);
    nxt();
    rst_n = 1'b1;
    nxt();
    chk("mrst_boot_valid", 32'(ifb.valid), 32'd0);
    nxt();
    chk_entry("mrst_first", 32'h0, 32'd0, 1'b0);

    // PC wrap: 0xFFFF_FFFC faults, the next entry is pc 0
    redirect = 1'b1;
    rpc      = 32'hFFFF_FFFC;
    nxt();
    chk("wrap_gap_valid", 32'(ifb.valid), 32'd0);
    redirect = 1'b0;
    nxt();
    chk("wrap_top_pc",    ifb.pc, 32'hFFFF_FFFC);
    chk("wrap_top_fault", 32'(ifb.fault), 32'd1);
    chk("wrap_top_inst",  ifb.inst, 32'h13);
    chk("wrap_addr",      32'(addr_b), 32'd0);
    nxt();
    chk_entry("wrap_zero", 32'h0, 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule : tb_fetch_stage
